// File: rtl/hsv_core_commit.sv
// In-order commit/writeback stage: tracks the unit order of issued instructions,
// retires unit results strictly in that order, writes the register file and raises flushes.
module hsv_core_commit #(
    parameter int ORDER_DEPTH = 8,
    parameter int NUM_REGS    = 32
) (
    input  logic                clk_core,
    input  logic                rst_core_n,
    input  logic                issue_valid,
    input  logic [1:0]          issue_unit,
    output logic                order_full,

    input  logic                alu_valid_i,
    input  logic [4:0]          alu_rd_addr,
    input  logic [31:0]         alu_rd_value,
    input  logic                alu_write,
    input  logic                alu_redirect,
    input  logic [31:0]         alu_redirect_pc,
    output logic                alu_stall_o,

    input  logic                branch_valid_i,
    input  logic [4:0]          branch_rd_addr,
    input  logic [31:0]         branch_rd_value,
    input  logic                branch_write,
    input  logic                branch_redirect,
    input  logic [31:0]         branch_redirect_pc,
    output logic                branch_stall_o,

    input  logic                ctrl_status_valid_i,
    input  logic [4:0]          ctrl_status_rd_addr,
    input  logic [31:0]         ctrl_status_rd_value,
    input  logic                ctrl_status_write,
    input  logic                ctrl_status_redirect,
    input  logic [31:0]         ctrl_status_redirect_pc,
    output logic                ctrl_status_stall_o,

    input  logic                mem_valid_i,
    input  logic [4:0]          mem_rd_addr,
    input  logic [31:0]         mem_rd_value,
    input  logic                mem_write,
    input  logic                mem_redirect,
    input  logic [31:0]         mem_redirect_pc,
    output logic                mem_stall_o,

    output logic                rd_wr_en,
    output logic [4:0]          rd_wr_addr,
    output logic [31:0]         rd_wr_data,
    output logic [NUM_REGS-1:0] commit_mask,
    output logic                flush_req,
    output logic [31:0]         flush_pc
);
    localparam int AW = $clog2(ORDER_DEPTH);
    localparam int PW = AW + 1;

    logic [1:0]          queue_q [ORDER_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

    logic                rd_wr_en_q;
    logic [4:0]          rd_wr_addr_q;
    logic [31:0]         rd_wr_data_q;
    logic [NUM_REGS-1:0] commit_mask_q;
    logic                flush_req_q;
    logic [31:0]         flush_pc_q;

    // Unit-indexed views of the four result ports (index = unit ID)
    logic [3:0]          valid_s, write_s, redirect_s, stall_s;
    logic [4:0]          rd_addr_s     [4];
    logic [31:0]         rd_value_s    [4];
    logic [31:0]         redirect_pc_s [4];

    logic                empty_s, full_s, push_s, commit_s, redirect_commit_s;
    logic [1:0]          head_s;

    assign valid_s    = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};
    assign write_s    = {mem_write, ctrl_status_write, branch_write, alu_write};
    assign redirect_s = {mem_redirect, ctrl_status_redirect, branch_redirect, alu_redirect};
    assign rd_addr_s[0] = alu_rd_addr;
    assign rd_addr_s[1] = branch_rd_addr;
    assign rd_addr_s[2] = ctrl_status_rd_addr;
    assign rd_addr_s[3] = mem_rd_addr;
    assign rd_value_s[0] = alu_rd_value;
    assign rd_value_s[1] = branch_rd_value;
    assign rd_value_s[2] = ctrl_status_rd_value;
    assign rd_value_s[3] = mem_rd_value;
    assign redirect_pc_s[0] = alu_redirect_pc;
    assign redirect_pc_s[1] = branch_redirect_pc;
    assign redirect_pc_s[2] = ctrl_status_redirect_pc;
    assign redirect_pc_s[3] = mem_redirect_pc;

    // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_s  = queue_q[rd_ptr_q[AW-1:0]];

    // Push/commit qualification; nothing moves during the flush cycle
    always_comb begin
        push_s            = 1'b0;
        commit_s          = 1'b0;
        redirect_commit_s = 1'b0;
        if (flush_req_q) begin
            push_s   = 1'b0;
            commit_s = 1'b0;
        end else begin
            push_s            = issue_valid & ~full_s;
            commit_s          = ~empty_s & valid_s[head_s];
            redirect_commit_s = ~empty_s & valid_s[head_s] & redirect_s[head_s];
        end
    end

    // Per-unit hold: a result waits until its unit is at the head of the order queue
    always_comb begin
        stall_s = 4'b0000;
        for (int u = 0; u < 4; u++) begin
            if (flush_req_q) begin
                stall_s[u] = 1'b0;
            end else begin
                stall_s[u] = valid_s[u] & ~(commit_s & (head_s == 2'(u)));
            end
        end
    end

    // Pointer next-state; a redirect discards every younger entry, including a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (redirect_commit_s) begin
            rd_ptr_d = wr_ptr_d;
        end else if (commit_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Order queue storage and pointers
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            for (int i = 0; i < ORDER_DEPTH; i++) begin
                queue_q[i] <= 2'b00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                queue_q[wr_ptr_q[AW-1:0]] <= issue_unit;
            end
        end
    end

    // Registered writeback and one-cycle flush
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            rd_wr_en_q    <= 1'b0;
            rd_wr_addr_q  <= 5'd0;
            rd_wr_data_q  <= 32'd0;
            commit_mask_q <= {NUM_REGS{1'b0}};
            flush_req_q   <= 1'b0;
            flush_pc_q    <= 32'd0;
        end else begin
            flush_req_q <= redirect_commit_s;
            if (commit_s) begin
                rd_wr_en_q    <= write_s[head_s] & (rd_addr_s[head_s] != 5'd0);
                rd_wr_addr_q  <= rd_addr_s[head_s];
                rd_wr_data_q  <= rd_value_s[head_s];
                commit_mask_q <= write_s[head_s] ? (NUM_REGS'(1) << rd_addr_s[head_s])
                                                 : {NUM_REGS{1'b0}};
            end else begin
                rd_wr_en_q    <= 1'b0;
                commit_mask_q <= {NUM_REGS{1'b0}};
            end
            if (redirect_commit_s) begin
                flush_pc_q <= redirect_pc_s[head_s];
            end
        end
    end

    assign order_full          = full_s;
    assign alu_stall_o         = stall_s[0];
    assign branch_stall_o      = stall_s[1];
    assign ctrl_status_stall_o = stall_s[2];
    assign mem_stall_o         = stall_s[3];
    assign rd_wr_en            = rd_wr_en_q;
    assign rd_wr_addr          = rd_wr_addr_q;
    assign rd_wr_data          = rd_wr_data_q;
    assign commit_mask         = commit_mask_q;
    assign flush_req           = flush_req_q;
    assign flush_pc            = flush_pc_q;

endmodule
